// File: rtl/serial_pkt_pkg.sv
// rtl/serial_pkt_pkg.sv - shared types and constants for the serial packet transmitter
package serial_pkt_pkg;

  localparam int BYTE_W = 8;
  localparam int GAP_MIN = 8;
  localparam int CSUM_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/tx_byte_fifo.sv
// rtl/tx_byte_fifo.sv - synchronous byte FIFO with occupancy count
module tx_byte_fifo
  import serial_pkt_pkg::*;
#(
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_push,
  input  logic [BYTE_W-1:0]             i_wdata,
  input  logic                          i_pop,
  output logic [BYTE_W-1:0]             o_rdata,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  logic [BYTE_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_do_push;
  logic              w_do_pop;

  // Full/empty come from the registered count only; no same-cycle bypass.
  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array, written at the write pointer.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally; the count carries one extra bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/serial_packet_transmitter.sv
// rtl/serial_packet_transmitter.sv - buffers length-prefixed packets and sends them LSB first; SERIAL_TX_CHECKSUM_EN appends a sum byte
module serial_packet_transmitter
  import serial_pkt_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int GAP_CYCLES = 8
) (
  input  logic              tClk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] Din,
  input  logic              Din_Valid,
  output logic              Din_Ready,
  output logic              Dout,
  output logic              Dout_Valid,
  output logic              Busy,
  output logic              Sent_flag,
  output logic              Len_Err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES);
  localparam logic [BYTE_W-1:0] MAX_LEN = BYTE_W'(FIFO_DEPTH - 1);
  localparam logic [BYTE_W-1:0] ONE_B = BYTE_W'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_ONE = GW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  // Write side
  logic              r_expect_hdr;
  logic [BYTE_W-1:0] r_pay_left;
  logic              r_len_err;
  logic [CW-1:0]     r_pkt_cnt;
  logic              w_accept;
  logic              w_hdr_bad;
  logic              w_push;
  logic              w_pkt_done;

  // FIFO interface
  logic [BYTE_W-1:0] w_fifo_rdata;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CW-1:0]     w_fifo_count;

  // Read side
  tx_state_t         r_state;
  logic [BYTE_W-1:0] r_shreg;
  logic [BYTE_W-1:0] r_bytes_left;
  logic [2:0]        r_bit_idx;
  logic [GW-1:0]     r_gap_cnt;
  logic              r_dout;
  logic              r_dout_valid;
  logic              r_sent;
  logic              w_start;
  logic              w_last_bit;
  logic              w_more_data;
  logic              w_pop;
  logic              w_pkt_sent;
`ifdef SERIAL_TX_CHECKSUM_EN
  logic [CSUM_W-1:0] r_csum;
  logic              r_csum_phase;
`endif

  assign Din_Ready  = (w_fifo_count != DEPTH_CNT);
  assign w_accept   = Din_Valid && !w_fifo_full;
  assign w_hdr_bad  = r_expect_hdr && (Din > MAX_LEN);
  assign w_push     = w_accept && !w_hdr_bad;
  assign w_pkt_done = w_accept && (r_expect_hdr ? (Din == '0) : (r_pay_left == ONE_B));

  assign w_start     = (r_state == IDLE) && (r_pkt_cnt != '0) && !w_fifo_empty;
  assign w_last_bit  = (r_state == SEND) && (r_bit_idx == 3'd7);
  assign w_more_data = (r_bytes_left != '0);
  assign w_pop       = w_start || (w_last_bit && w_more_data);
`ifdef SERIAL_TX_CHECKSUM_EN
  assign w_pkt_sent  = w_last_bit && !w_more_data && r_csum_phase;
`else
  assign w_pkt_sent  = w_last_bit && !w_more_data;
`endif

  assign Dout       = r_dout;
  assign Dout_Valid = r_dout_valid;
  assign Sent_flag  = r_sent;
  assign Len_Err    = r_len_err;
  assign Busy       = (r_state != IDLE);

  tx_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (tClk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (Din),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Header tracker: classify each accepted byte and drop oversize headers.
  always_ff @(posedge tClk or negedge rst_n) begin
    if (!rst_n) begin
      r_expect_hdr <= 1'b1;
      r_pay_left   <= '0;
      r_len_err    <= 1'b0;
    end else begin
      r_len_err <= w_accept && w_hdr_bad;
      if (w_accept) begin
        if (r_expect_hdr) begin
          if (!w_hdr_bad && (Din != '0)) begin
            r_expect_hdr <= 1'b0;
            r_pay_left   <= Din;
          end
        end else begin
          r_pay_left <= r_pay_left - ONE_B;
          if (r_pay_left == ONE_B) begin
            r_expect_hdr <= 1'b1;
          end
        end
      end
    end
  end

  // Count of fully buffered packets; only these may start transmitting.
  always_ff @(posedge tClk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt <= '0;
    end else begin
      case ({w_pkt_done, w_pkt_sent})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + CNT_ONE;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - CNT_ONE;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  // Transmit FSM: serialise header and payload back to back, then hold a guard gap.
  always_ff @(posedge tClk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_bytes_left <= '0;
      r_bit_idx    <= '0;
      r_gap_cnt    <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_sent       <= 1'b0;
`ifdef SERIAL_TX_CHECKSUM_EN
      r_csum       <= '0;
      r_csum_phase <= 1'b0;
`endif
    end else begin
      r_sent <= 1'b0;
      case (r_state)
        IDLE: begin
          r_dout       <= 1'b0;
          r_dout_valid <= 1'b0;
          if (w_start) begin
            r_state      <= SEND;
            r_shreg      <= w_fifo_rdata;
            r_bytes_left <= w_fifo_rdata;
            r_bit_idx    <= '0;
`ifdef SERIAL_TX_CHECKSUM_EN
            r_csum       <= w_fifo_rdata;
            r_csum_phase <= 1'b0;
`endif
          end
        end
        SEND: begin
          r_dout       <= r_shreg[r_bit_idx];
          r_dout_valid <= 1'b1;
          r_bit_idx    <= r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            if (w_more_data) begin
              // Reload on the last bit so the next byte follows without a bubble.
              r_shreg      <= w_fifo_rdata;
              r_bytes_left <= r_bytes_left - ONE_B;
`ifdef SERIAL_TX_CHECKSUM_EN
              r_csum       <= r_csum + w_fifo_rdata;
`endif
            end
`ifdef SERIAL_TX_CHECKSUM_EN
            else if (!r_csum_phase) begin
              r_shreg      <= r_csum;
              r_csum_phase <= 1'b1;
            end
`endif
            else begin
              r_sent    <= 1'b1;
              r_state   <= GAP;
              r_gap_cnt <= '0;
            end
          end
        end
        GAP: begin
          r_dout       <= 1'b0;
          r_dout_valid <= 1'b0;
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_ONE;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_dout       <= 1'b0;
          r_dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_packet_transmitter.sv
// tb/tb_serial_packet_transmitter.sv - self-checking bench for serial_packet_transmitter
module tb_serial_packet_transmitter;

  localparam int FIFO_DEPTH = 32;
  localparam int GAP_CYCLES = 8;
  localparam int MAX_LEN = FIFO_DEPTH - 1;

  logic       tClk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] Din = 8'h00;
  logic       Din_Valid = 1'b0;
  logic       Din_Ready;
  logic       Dout;
  logic       Dout_Valid;
  logic       Busy;
  logic       Sent_flag;
  logic       Len_Err;

  always #5 tClk = ~tClk;

  serial_packet_transmitter #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .tClk       (tClk),
    .rst_n      (rst_n),
    .Din        (Din),
    .Din_Valid  (Din_Valid),
    .Din_Ready  (Din_Ready),
    .Dout       (Dout),
    .Dout_Valid (Dout_Valid),
    .Busy       (Busy),
    .Sent_flag  (Sent_flag),
    .Len_Err    (Len_Err)
  );

  int vec_cnt = 0;
  int miscmp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: parse accepted bytes into expected on-line packets.
  logic [7:0] exp_bytes[$];
  int         exp_len_q[$];
  int         exp_lenerr = 0;
  bit         m_in_hdr = 1'b1;
  int         m_left = 0;
  logic [7:0] m_cur[$];

  task automatic model_close();
    int sum;
    sum = 0;
    foreach (m_cur[i]) sum += int'(m_cur[i]);
`ifdef SERIAL_TX_CHECKSUM_EN
    m_cur.push_back(8'(sum % 256));
`endif
    foreach (m_cur[i]) exp_bytes.push_back(m_cur[i]);
    exp_len_q.push_back(m_cur.size());
    m_cur.delete();
  endtask

  task automatic model_accept(input logic [7:0] b);
    if (m_in_hdr) begin
      if (int'(b) > MAX_LEN) begin
        exp_lenerr++;
      end else begin
        m_cur.delete();
        m_cur.push_back(b);
        m_left = int'(b);
        if (m_left == 0) model_close();
        else m_in_hdr = 1'b0;
      end
    end else begin
      m_cur.push_back(b);
      m_left--;
      if (m_left == 0) begin
        model_close();
        m_in_hdr = 1'b1;
      end
    end
  endtask

  // Line monitor: reassemble bytes, check contiguity, gaps and packet contents.
  int         mon_line_bits = 0;
  int         mon_idle = 0;
  int         mon_pkts = 0;
  int         mon_lenerr = 0;
  int         mon_last_bits = 0;
  bit         mon_seen = 1'b0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] mon_pkt[$];
  logic [31:0] mon_last_word = 32'h0;

  task automatic mon_finish();
    logic [31:0] w;
    logic [7:0]  e;
    int          n;
    int          el;
    bit          ok;
    w = '0;
    n = mon_pkt.size();
    for (int i = 0; i < n && i < 4; i++) w[8*i +: 8] = mon_pkt[i];
    mon_last_word = w;
    mon_last_bits = mon_line_bits;
    mon_pkts++;
    mon_seen = 1'b1;
    vec_cnt++;
    if (exp_len_q.size() == 0) begin
      miscmp++;
      $display("FAIL unexpected packet: got %0d bits word 0x%08h, required none", mon_line_bits, w);
    end else begin
      el = exp_len_q.pop_front();
      ok = (mon_line_bits == 8 * el);
      for (int i = 0; i < el; i++) begin
        e = exp_bytes.pop_front();
        if (i >= n || mon_pkt[i] != e) ok = 1'b0;
      end
      if (!ok) begin
        miscmp++;
        $display("FAIL packet: got %0d bits word 0x%08h, required %0d bits", mon_line_bits, w, 8 * el);
      end
    end
    mon_line_bits = 0;
    mon_pkt.delete();
  endtask

  always @(negedge tClk) begin
    if (!rst_n) begin
      mon_line_bits = 0;
      mon_idle = 0;
      mon_seen = 1'b0;
      mon_pkt.delete();
    end else begin
      if (Len_Err) mon_lenerr++;
      if (Dout_Valid) begin
        if (mon_line_bits == 0 && mon_seen) begin
          vec_cnt++;
          if (mon_idle < GAP_CYCLES + 1) begin
            miscmp++;
            $display("FAIL gap: got %0d idle cycles, required >= %0d", mon_idle, GAP_CYCLES + 1);
          end
        end
        mon_byte[3'(mon_line_bits % 8)] = Dout;
        mon_line_bits++;
        if (mon_line_bits % 8 == 0) mon_pkt.push_back(mon_byte);
        mon_idle = 0;
        if (Sent_flag) mon_finish();
      end else begin
        mon_idle++;
        if (mon_line_bits != 0) begin
          vec_cnt++;
          miscmp++;
          $display("FAIL contiguity: valid dropped after %0d bits, required Sent_flag first", mon_line_bits);
          mon_line_bits = 0;
          mon_pkt.delete();
        end
        if (Sent_flag) begin
          vec_cnt++;
          miscmp++;
          $display("FAIL sent_flag: got 1 with Dout_Valid 0, required 0");
        end
      end
    end
  end

  // Drive one byte starting at a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int tries;
    tries = 0;
    Din = b;
    Din_Valid = 1'b1;
    while (!Din_Ready && tries < 2000) begin
      @(negedge tClk);
      tries++;
    end
    if (!Din_Ready) begin
      vec_cnt++;
      miscmp++;
      $display("FAIL din_ready timeout: got 0, required 1 within 2000 cycles");
      Din_Valid = 1'b0;
      return;
    end
    @(posedge tClk);
    model_accept(b);
    @(negedge tClk);
    Din_Valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_len_q.size() != 0 || Busy || Dout_Valid) && c < 20000) begin
      @(negedge tClk);
      #1;
      c++;
    end
    chk("drain", {63'd0, (exp_len_q.size() == 0) && !Busy}, 64'd1);
  endtask

  typedef struct {
    logic [31:0] din;
    int          n;
    int          exp_pkts;
    int          exp_bits;
    logic [31:0] exp_word;
    int          exp_lenerr;
  } vec_t;

  vec_t tbl[5];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int p0;
    int l0;
    int c;
    logic [7:0] h;
    logic [31:0] lat_bytes;
    logic [7:0] tmp;

`ifdef SERIAL_TX_CHECKSUM_EN
    tbl[0] = '{32'h003CA502, 3, 1, 32, 32'hE33CA502, 0};
    tbl[1] = '{32'h00000000, 1, 1, 16, 32'h00000000, 0};
    tbl[2] = '{32'h00FF0120, 3, 1, 24, 32'h0000FF01, 1};
    tbl[3] = '{32'h00001101, 2, 1, 24, 32'h00121101, 0};
    tbl[4] = '{32'h00201002, 3, 1, 32, 32'h32201002, 0};
`else
    tbl[0] = '{32'h003CA502, 3, 1, 24, 32'h003CA502, 0};
    tbl[1] = '{32'h00000000, 1, 1, 8,  32'h00000000, 0};
    tbl[2] = '{32'h00FF0120, 3, 1, 16, 32'h0000FF01, 1};
    tbl[3] = '{32'h00001101, 2, 1, 16, 32'h00001101, 0};
    tbl[4] = '{32'h00201002, 3, 1, 24, 32'h00201002, 0};
`endif

    repeat (3) @(negedge tClk);
    #1;
    chk("reset Dout", {63'd0, Dout}, 64'd0);
    chk("reset Dout_Valid", {63'd0, Dout_Valid}, 64'd0);
    chk("reset Busy", {63'd0, Busy}, 64'd0);
    chk("reset Sent_flag", {63'd0, Sent_flag}, 64'd0);
    chk("reset Len_Err", {63'd0, Len_Err}, 64'd0);
    chk("reset Din_Ready", {63'd0, Din_Ready}, 64'd1);
    @(negedge tClk);
    rst_n = 1'b1;
    @(negedge tClk);

    foreach (tbl[i]) begin
      p0 = mon_pkts;
      l0 = mon_lenerr;
      for (int j = 0; j < tbl[i].n; j++) begin
        tmp = tbl[i].din[8*j +: 8];
        send_byte(tmp);
      end
      drain();
      chk($sformatf("v%0d pkts", i), 64'(mon_pkts - p0), 64'(tbl[i].exp_pkts));
      chk($sformatf("v%0d bits", i), 64'(mon_last_bits), 64'(tbl[i].exp_bits));
      chk($sformatf("v%0d word", i), {32'd0, mon_last_word}, {32'd0, tbl[i].exp_word});
      chk($sformatf("v%0d len_err", i), 64'(mon_lenerr - l0), 64'(tbl[i].exp_lenerr));
    end

    // Len_Err pulses exactly one cycle after an oversize header.
    send_byte(8'hFF);
    chk("len_err pulse", {63'd0, Len_Err}, 64'd1);
    @(negedge tClk);
    chk("len_err one cycle", {63'd0, Len_Err}, 64'd0);
    drain();

    // Toggling Din_Valid: silent until last byte, then burst two edges later.
    lat_bytes = 32'h81C35A03;
    for (int j = 0; j < 4; j++) begin
      tmp = lat_bytes[8*j +: 8];
      send_byte(tmp);
      if (j < 3) begin
        chk("no early output", {63'd0, Dout_Valid}, 64'd0);
        @(negedge tClk);
      end
    end
    chk("latency k valid", {63'd0, Dout_Valid}, 64'd0);
    @(negedge tClk);
    chk("latency k+1 valid", {63'd0, Dout_Valid}, 64'd0);
    chk("latency k+1 busy", {63'd0, Busy}, 64'd1);
    @(negedge tClk);
    chk("latency k+2 valid", {63'd0, Dout_Valid}, 64'd1);
    chk("latency k+2 bit0", {63'd0, Dout}, 64'd1);
    drain();

    // Back-to-back packets; monitor enforces the inter-packet gap.
    send_byte(8'h01); send_byte(8'h11);
    send_byte(8'h01); send_byte(8'h22);
    drain();

    // Din_Ready drops only when the count reaches FIFO_DEPTH.
    send_byte(8'(MAX_LEN));
    for (int j = 0; j < MAX_LEN - 1; j++) send_byte(8'(j * 7 + 3));
    chk("ready at depth-1", {63'd0, Din_Ready}, 64'd1);
    send_byte(8'hEE);
    chk("ready at depth", {63'd0, Din_Ready}, 64'd0);
    @(negedge tClk);
    chk("ready after pop", {63'd0, Din_Ready}, 64'd1);
    drain();

    // Reset during the third byte on the line.
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    c = 0;
    while (mon_line_bits < 18 && c < 500) begin
      @(negedge tClk);
      #1;
      c++;
    end
    chk("reached 3rd byte", {63'd0, mon_line_bits >= 18}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset Dout_Valid", {63'd0, Dout_Valid}, 64'd0);
    chk("mid reset Busy", {63'd0, Busy}, 64'd0);
    chk("mid reset Din_Ready", {63'd0, Din_Ready}, 64'd1);
    exp_bytes.delete();
    exp_len_q.delete();
    m_cur.delete();
    m_in_hdr = 1'b1;
    @(negedge tClk);
    @(negedge tClk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge tClk);
      chk("post reset idle", {63'd0, Busy}, 64'd0);
    end
    p0 = mon_pkts;
    send_byte(8'h01); send_byte(8'h77);
    drain();
    chk("post reset packet", 64'(mon_pkts - p0), 64'd1);

    // Randomized packets with random input gaps and occasional bad headers.
    for (int p = 0; p < 30; p++) begin
      if ($urandom_range(0, 7) == 0) h = 8'($urandom_range(MAX_LEN + 1, 255));
      else h = 8'($urandom_range(0, MAX_LEN));
      send_byte(h);
      if (int'(h) <= MAX_LEN) begin
        for (int j = 0; j < int'(h); j++) begin
          send_byte(8'($urandom));
          repeat ($urandom_range(0, 2)) @(negedge tClk);
        end
      end
    end
    drain();

    chk("len_err total", 64'(mon_lenerr), 64'(exp_lenerr));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule

// File: doc/serial_packet_transmitter.md
Name: serial_packet_transmitter

Overview:
- Upstream stage of the serial packet receiver.
- Accepts bytes over a ready/valid handshake and buffers each full packet in a FIFO. A packet is a length byte L followed by L payload bytes.
- Once the whole packet is buffered, it sends the packet on Dout/Dout_Valid, LSB first, with no gaps between bytes.
- After the packet it holds Dout_Valid low for a guard gap. The receiver uses this gap as its trailing zero byte.

Parameters:
- FIFO_DEPTH, 32: byte FIFO entries, power of two, at least 4. Maximum payload MAX_LEN = FIFO_DEPTH-1.
- GAP_CYCLES, 8: idle cycles with Dout_Valid=0 after each packet. Must be at least 8.

Ports:
- tClk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- Din  input  8  byte to enqueue (header or payload).
- Din_Valid  input  1  Din is valid this cycle.
- Din_Ready  output  1  block can accept Din; equals "FIFO not full".
- Dout  output  1  serial data bit.
- Dout_Valid  output  1  Dout carries a packet bit.
- Busy  output  1  high in SEND and GAP.
- Sent_flag  output  1  one-cycle pulse on the last bit of each packet.
- Len_Err  output  1  one-cycle pulse when a header byte exceeds MAX_LEN.

Behaviour:
- Reset values (async on rst_n=0): Dout=0, Dout_Valid=0, Busy=0, Sent_flag=0, Len_Err=0. FIFO is empty and the write side expects a header. Reset in mid-packet aborts immediately; Dout_Valid drops asynchronously and no partial byte completes.
- Write side:
  - A byte is accepted when Din_Valid and Din_Ready are both high.
  - The first accepted byte after reset, or after a packet's last payload byte, is a header.
  - If header > MAX_LEN: the byte is not stored, Len_Err pulses in the next cycle, and the next byte is again treated as a header.
  - Otherwise the header is stored and a payload counter is loaded with L. With L=0 the next byte is a header.
  - The write side counts complete packets queued, pkt_cnt.
- FSM, states IDLE, SEND, GAP:
  - IDLE: if pkt_cnt>0, go to SEND. Load shift register with the FIFO head byte (pop), load bytes_left = header value, bit_idx=0.
  - SEND: Dout = shreg[bit_idx] and Dout_Valid=1. Both outputs are registered.
    - At bit_idx=7 with bytes_left>0: pop the next byte into the shift register and decrement bytes_left, so the next byte follows with no bubble.
    - At bit_idx=7 with bytes_left=0: Sent_flag=1 in that cycle, decrement pkt_cnt, go to GAP.
  - GAP: Dout=0, Dout_Valid=0 for GAP_CYCLES cycles, then go to IDLE.
- Latency: if a packet's last payload byte is accepted at edge k, the header LSB appears with Dout_Valid=1 after edge k+2. That is IDLE detection plus the registered output.
- Packet length on the line is (L+1)*8 cycles. Between packets, Dout_Valid stays low for at least GAP_CYCLES+1 cycles.
- Simultaneous push and pop are allowed; a push is accepted when the FIFO is full only if a pop happens in the same cycle? No: Din_Ready is based on the registered count only, with no bypass.
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count has one extra bit.
- Deadlock guard: MAX_LEN = FIFO_DEPTH-1, so a full legal packet always fits.

Optional Feature:
- SERIAL_TX_CHECKSUM_EN defined: after the last payload byte, one extra byte is sent contiguously. It is the 8-bit modulo-256 sum of the header and all payload bytes.
  - The header value is unchanged.
  - Sent_flag moves to the checksum's last bit.
  - Line length becomes (L+2)*8 cycles.
- Not defined: no checksum byte and no summing logic.

Decomposition:
- Package serial_pkt_pkg holds:
  - tx_state_t enum (IDLE, SEND, GAP);
  - BYTE_W=8;
  - GAP_MIN=8;
  - the checksum width constant.
- Sub-module tx_byte_fifo: synchronous FIFO, FIFO_DEPTH x 8, with push, pop, full, empty, count. The top level holds the write-side header tracker, pkt_cnt and the FSM.

Test Plan:
- Header 0x02, payload 0xA5, 0x3C (no gaps on input) -> 24 contiguous Dout_Valid cycles with bits 0,1,0,0,0,0,0,0 / 1,0,1,0,0,1,0,1 / 0,0,1,1,1,1,0,0. Sent_flag on cycle 24, then 8 cycles with Dout_Valid=0.
- Header 0x00 -> exactly 8 Dout_Valid cycles, all bits 0, with Sent_flag on the 8th.
- Header 0x20 with FIFO_DEPTH=32 -> Len_Err pulse, nothing stored. A following 0x01, 0xFF is sent as a valid 16-bit packet.
- Input packet with Din_Valid toggling every other cycle -> no output until the last payload byte is accepted, then a contiguous burst starting 2 edges later.
- Two back-to-back packets 0x01,0x11 and 0x01,0x22 -> 16-bit burst, at least 9 idle cycles, 16-bit burst. Din_Ready deasserts only when the count reaches 32.
- rst_n low during the 3rd byte of a transmission -> Dout_Valid=0 immediately, Busy=0, FIFO empty. A new packet after release is sent correctly.
- With SERIAL_TX_CHECKSUM_EN, packet 0x02,0x10,0x20 -> 4th byte 0x32 is sent, with Sent_flag at cycle 32.
